// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op codes and controller state encoding for muldiv_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Brief    : One iteration of shift-add multiply or restoring shift-subtract divide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] addend;
    logic [WIDTH-1:0] new_rem;
    logic           q_bit;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd_i};
        q_bit   = (rem_sh >= {1'b0, opnd_i});
        new_rem = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        addend  = acc_i[0] ? sum : {1'b0, acc_i[2*WIDTH-1:WIDTH]};
        acc_o   = '0;
        // Divide: {remainder, quotient} shifts left; multiply: {product, multiplier} shifts right.
        if (is_div_i) begin
            acc_o = {new_rem, acc_i[WIDTH-2:0], q_bit};
        end else begin
            acc_o = {addend, acc_i[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : Multi-cycle mult/div sequencer owning HI/LO, with pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               sgn_diff_q, sgn_diff_d;
    logic               a_neg_q, a_neg_d;
    logic               busy_q;

    logic             start_ok, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quot, rem;

    assign start_ok  = start && is_muldiv_op(op) && (state_q == IDLE) && !flush;
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = op_signed && src_a[WIDTH-1];
    assign b_neg     = op_signed && src_b[WIDTH-1];
    assign mag_a     = a_neg ? -src_a : src_a;
    assign mag_b     = b_neg ? -src_b : src_b;
    assign quot      = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        sgn_diff_d = sgn_diff_q;
        a_neg_d    = a_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    is_div_d   = op_div;
                    sgn_diff_d = a_neg ^ b_neg;
                    a_neg_d    = a_neg;
                    a_raw_d    = src_a;
                    acc_d      = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                    opnd_d     = op_div ? mag_b : mag_a;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    if (is_div_q) begin
                        // Divide by zero reports all-ones quotient and the original dividend.
                        if (opnd_q == '0) begin
                            lo_d = '1;
                            hi_d = a_raw_q;
                        end else begin
                            lo_d = sgn_diff_q ? -quot : quot;
                            hi_d = a_neg_q ? -rem : rem;
                        end
                    end else begin
                        {hi_d, lo_d} = sgn_diff_q ? -acc_q : acc_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            sgn_diff_q <= 1'b0;
            a_neg_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            sgn_diff_q <= sgn_diff_d;
            a_neg_q    <= a_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign stall = ((state_q == IDLE) && start_ok) || ((state_q != IDLE) && !flush);
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle controller for the mult/multu/div/divu operations that the ALU decoder emits. It sits beside the EX stage and owns the architectural HI/LO registers. It sequences an iterative shift-add multiplier and a restoring divider, and stalls the pipeline while an operation is in flight. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 2
CNT_W, $clog2(WIDTH), width of the iteration counter

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  EX stage holds a mult/div instruction
op  in  5  alucontrol code: 10001 mult, 10010 multu, 10011 div, 10100 divu
src_a  in  WIDTH  rs operand (multiplicand / dividend)
src_b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  exception or flush; cancels an in-flight operation
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wdata  in  WIDTH  mthi/mtlo data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
stall  out  1  freeze the pipeline
busy  out  1  state != IDLE

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE; counter is 0.
  - hi, lo and the internal accumulators are 0; stall=0, busy=0.
  - Reset mid-operation aborts it with no HI/LO update.
- States: IDLE, BUSY, FIX.
- Valid start: start=1, op is one of the 4 codes, state=IDLE, flush=0.
  - Any other op with start=1 is ignored.
  - start in BUSY/FIX is ignored.
- Timing for a valid start sampled at edge E0:
  - E0: latch op and operand signs. Load magnitudes: abs() for mult/div, raw for multu/divu. Clear the counter. IDLE->BUSY.
  - E1..E32 (WIDTH edges): one iteration each.
    - Multiply: shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract, giving quotient and partial remainder.
    - The counter increments each edge. BUSY->FIX when counter == WIDTH-1.
  - E33 (FIX): apply sign fix, write hi/lo, FIX->IDLE.
    - Multiply: negate the 2·WIDTH product if the signs differ (mult only). hi = upper WIDTH bits, lo = lower WIDTH bits.
    - Divide: lo = quotient, negated if the signs differ (div only). hi = remainder, negated if the dividend is negative (div only).
    - Divide by zero (either divu/div): lo = all ones, hi = raw src_a as latched. This overrides the sign fix.
    - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural wrap, no trap).
- stall = (IDLE & valid start) | BUSY | FIX. It is combinational and high for exactly WIDTH+2 cycles. New hi/lo are visible in the first cycle stall is low.
- busy is registered: high in BUSY and FIX.
- flush:
  - In BUSY/FIX: go to IDLE next edge, leave hi/lo unchanged, stall low in the flush cycle.
  - In IDLE: suppresses start.
- hi_we/lo_we:
  - Honoured only in IDLE with no valid start; hi/lo are written at the next edge.
  - If a valid start occurs in the same cycle, start wins and the writes are dropped.
  - Writes in BUSY/FIX are ignored; the bench flags them as a protocol error.
- hi/lo hold their values except on FIX completion or an honoured write.

Decomposition:
- Package muldiv_pkg holds:
  - op constants OP_MULT=5'b10001, OP_MULTU=5'b10010, OP_DIV=5'b10011, OP_DIVU=5'b10100, shared with aludec;
  - the state enum {IDLE, BUSY, FIX}.
- One natural sub-module, muldiv_step: a combinational single-iteration datapath. Inputs are accumulator, operand and mode; the output is the next accumulator. It is instantiated once.

Test Plan:
- multu 3×5 at E0 → stall high 34 cycles; then hi=0x00000000, lo=0x0000000F, busy=0.
- mult 0xFFFFFFFE×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; mult 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- div 0xFFFFFFF9 (−7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 → lo=0xFFFFFFFF, hi=7. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi 0x1234, then mtlo 0x5678 in IDLE → hi=0x1234, lo=0x5678 next cycle. start with hi_we=1 in the same cycle → write dropped, op result lands.
- Preload hi/lo, start div, flush at cycle 10 → state IDLE next edge, stall low, hi/lo unchanged. start in the same cycle as flush in IDLE → no op.
- resetn pulsed low mid-BUSY → outputs 0 immediately (async). start during BUSY and an illegal op (5'b00100) with start → ignored.
